// File: rtl/rename_map_table_if.sv
// rename_map_table_if
//   Bundles the rename-stage traffic of rename_map_table: decoded lanes, free-list
//   offers, rename results, checkpoint status, ROB commits and branch resolution.
//   master : decode / free list / ROB / branch unit side (drives requests)
//   slave  : the rename map itself (drives renamed tags, stall, checkpoint info)
//   Lane i of every packed vector sits at [i*W +: W].
interface rename_map_table_if #(
    parameter int unsigned LANES     = 3,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned NUM_CKPT  = 4,
    parameter int unsigned AW        = $clog2(ARCH_REGS),
    parameter int unsigned PW        = $clog2(PHYS_REGS),
    parameter int unsigned CW        = $clog2(NUM_CKPT)
);
    // Decode group and free-list offer
    logic [LANES-1:0]    dec_valid;
    logic [LANES*AW-1:0] rs1_arch;
    logic [LANES*AW-1:0] rs2_arch;
    logic [LANES*AW-1:0] rd_arch;
    logic [LANES-1:0]    rd_we;
    logic [LANES*PW-1:0] new_tag;
    logic [LANES-1:0]    new_tag_valid;
    logic [LANES-1:0]    is_branch;
    // Rename results
    logic [LANES*PW-1:0] rs1_phys;
    logic [LANES*PW-1:0] rs2_phys;
    logic [LANES*PW-1:0] rd_phys;
    logic [LANES*PW-1:0] old_rd_phys;
    logic [LANES-1:0]    rename_valid;
    logic [LANES-1:0]    tag_consume;
    logic [LANES*CW-1:0] ckpt_id;
    logic                stall;
    logic [CW:0]         ckpt_free;
    // Commit and recovery
    logic [LANES-1:0]    commit_valid;
    logic [LANES*AW-1:0] commit_arch;
    logic [LANES*PW-1:0] commit_tag;
    logic                br_resolve_valid;
    logic [CW-1:0]       br_resolve_id;
    logic                br_mispredict;
    logic                flush_all;

    modport master (
        output dec_valid, rs1_arch, rs2_arch, rd_arch, rd_we, new_tag, new_tag_valid,
               is_branch, commit_valid, commit_arch, commit_tag, br_resolve_valid,
               br_resolve_id, br_mispredict, flush_all,
        input  rs1_phys, rs2_phys, rd_phys, old_rd_phys, rename_valid, tag_consume,
               ckpt_id, stall, ckpt_free
    );

    modport slave (
        input  dec_valid, rs1_arch, rs2_arch, rd_arch, rd_we, new_tag, new_tag_valid,
               is_branch, commit_valid, commit_arch, commit_tag, br_resolve_valid,
               br_resolve_id, br_mispredict, flush_all,
        output rs1_phys, rs2_phys, rd_phys, old_rd_phys, rename_valid, tag_consume,
               ckpt_id, stall, ckpt_free
    );
endinterface

// File: rtl/rename_map_table.sv
// rename_map_table
//   N-wide architectural-to-physical register rename map. Tags 0..ARCH_REGS-1 name the
//   architectural file, higher tags name in-flight results. A decode group is renamed
//   atomically using per-lane tags from an external free list. ROB commits clear a
//   mapping back to its architectural tag when it still points at the committed tag.
//
//   Optional feature (macro RENAME_CHECKPOINT_EN): an ordered circular stack of map
//   snapshots for single-cycle branch-mispredict recovery. Without it, is_branch and
//   br_resolve_* are ignored, ckpt_id/ckpt_free read 0, and only flush_all recovers.
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (map = identity, stack empty)
//   bus   : rename_map_table_if.slave (decode group in, renamed tags/stall out,
//           commit and branch-resolution in)
module rename_map_table #(
    parameter int unsigned LANES     = 3,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned NUM_CKPT  = 4,
    parameter int unsigned AW        = $clog2(ARCH_REGS),
    parameter int unsigned PW        = $clog2(PHYS_REGS),
    parameter int unsigned CW        = $clog2(NUM_CKPT)
) (
    input logic               clk,
    input logic               reset,
    rename_map_table_if.slave bus
);

    localparam int unsigned CNTW = CW + 1;

    typedef logic [PW-1:0] tag_t;

    // Lane unpacking
    logic [AW-1:0]    rs1_a [LANES];
    logic [AW-1:0]    rs2_a [LANES];
    logic [AW-1:0]    rd_a  [LANES];
    logic [AW-1:0]    cm_a  [LANES];
    tag_t             nt    [LANES];
    tag_t             cm_t  [LANES];
    logic [LANES-1:0] need;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign rs1_a[g] = bus.rs1_arch[g*AW +: AW];
        assign rs2_a[g] = bus.rs2_arch[g*AW +: AW];
        assign rd_a[g]  = bus.rd_arch[g*AW +: AW];
        assign cm_a[g]  = bus.commit_arch[g*AW +: AW];
        assign nt[g]    = bus.new_tag[g*PW +: PW];
        assign cm_t[g]  = bus.commit_tag[g*PW +: PW];
        // x0 is hard-wired to tag 0, so writing it never needs a tag
        assign need[g]  = bus.dec_valid[g] & bus.rd_we[g] & (rd_a[g] != '0);
    end

    // Live map
    tag_t map_q [ARCH_REGS];
    tag_t map_d [ARCH_REGS];

    logic            tags_ok;
    logic            ckpt_ok;
    logic            misp;
    logic            stall_w;
    logic            accept;
    logic [CNTW-1:0] ckpt_free_w;
    int unsigned     br_n;

`ifdef RENAME_CHECKPOINT_EN
    tag_t                ckpt_q [NUM_CKPT][ARCH_REGS];
    tag_t                ckpt_d [NUM_CKPT][ARCH_REGS];
    logic [NUM_CKPT-1:0] done_q, done_d;
    logic [CW-1:0]       head_q, head_d;
    logic [CW-1:0]       tail_q, tail_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                pop;

    assign misp        = bus.br_resolve_valid & bus.br_mispredict;
    assign ckpt_free_w = CNTW'(NUM_CKPT) - count_q;
    // A done branch cannot also be mispredicted; guard keeps the count sane if it is
    assign pop         = (count_q != '0) && done_q[head_q] &&
                         !(misp && (bus.br_resolve_id == head_q));
`else
    assign misp        = 1'b0;
    assign ckpt_free_w = '0;

    logic unused_ckpt;
    assign unused_ckpt = ^{bus.is_branch, bus.br_resolve_valid, bus.br_resolve_id,
                           bus.br_mispredict};
`endif

    // Group acceptance
    always_comb begin
        tags_ok = 1'b1;
        br_n    = 0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (need[i] && !bus.new_tag_valid[i]) tags_ok = 1'b0;
            if (bus.dec_valid[i] && bus.is_branch[i]) br_n = br_n + 1;
        end
`ifdef RENAME_CHECKPOINT_EN
        ckpt_ok = (br_n <= 32'(ckpt_free_w));
`else
        ckpt_ok = 1'b1;
`endif
    end

    assign stall_w = bus.flush_all | misp | ~tags_ok | ~ckpt_ok;
    assign accept  = ~stall_w;

    // Rename outputs: sources read the registered map, bypassed by older lanes of the
    // same group. The ascending scan leaves the youngest older writer in place.
    logic [LANES*PW-1:0] rs1_w, rs2_w, rd_w, old_w;
    logic [LANES*CW-1:0] ckpt_id_w;

    always_comb begin
        tag_t s1, s2, od;
`ifdef RENAME_CHECKPOINT_EN
        logic [CW-1:0] slot;
        slot = tail_q;
`endif
        rs1_w     = '0;
        rs2_w     = '0;
        rd_w      = '0;
        old_w     = '0;
        ckpt_id_w = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            s1 = map_q[rs1_a[j]];
            s2 = map_q[rs2_a[j]];
            od = map_q[rd_a[j]];
            for (int unsigned i = 0; i < LANES; i++) begin
                if (i < j && need[i]) begin
                    if (rd_a[i] == rs1_a[j]) s1 = nt[i];
                    if (rd_a[i] == rs2_a[j]) s2 = nt[i];
                    if (rd_a[i] == rd_a[j])  od = nt[i];
                end
            end
            if (bus.dec_valid[j] && rs1_a[j] != '0) rs1_w[j*PW +: PW] = s1;
            if (bus.dec_valid[j] && rs2_a[j] != '0) rs2_w[j*PW +: PW] = s2;
            if (need[j]) begin
                rd_w[j*PW +: PW]  = nt[j];
                old_w[j*PW +: PW] = od;
            end
`ifdef RENAME_CHECKPOINT_EN
            if (accept && bus.dec_valid[j] && bus.is_branch[j]) begin
                ckpt_id_w[j*CW +: CW] = slot;
                slot = slot + 1'b1;
            end
`endif
        end
    end

    assign bus.rs1_phys     = rs1_w;
    assign bus.rs2_phys     = rs2_w;
    assign bus.rd_phys      = rd_w;
    assign bus.old_rd_phys  = old_w;
    assign bus.rename_valid = accept ? bus.dec_valid : '0;
    assign bus.tag_consume  = accept ? need : '0;
    assign bus.ckpt_id      = ckpt_id_w;
    assign bus.stall        = stall_w;
    assign bus.ckpt_free    = ckpt_free_w;

    // Map and snapshot next state: commit clears first, then restore or rename on top
    always_comb begin
`ifdef RENAME_CHECKPOINT_EN
        logic [CW-1:0] slot;
        slot = tail_q;
        for (int unsigned s = 0; s < NUM_CKPT; s++) begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) ckpt_d[s][r] = ckpt_q[s][r];
        end
`endif
        for (int unsigned r = 0; r < ARCH_REGS; r++) map_d[r] = map_q[r];

        for (int unsigned k = 0; k < LANES; k++) begin
            if (bus.commit_valid[k]) begin
                if (map_d[cm_a[k]] == cm_t[k]) map_d[cm_a[k]] = tag_t'(cm_a[k]);
`ifdef RENAME_CHECKPOINT_EN
                // Free slots are cleared too; they are overwritten on allocation
                for (int unsigned s = 0; s < NUM_CKPT; s++) begin
                    if (ckpt_d[s][cm_a[k]] == cm_t[k]) ckpt_d[s][cm_a[k]] = tag_t'(cm_a[k]);
                end
`endif
            end
        end

        if (bus.flush_all) begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) map_d[r] = tag_t'(r);
        end
`ifdef RENAME_CHECKPOINT_EN
        else if (misp) begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) begin
                map_d[r] = ckpt_d[bus.br_resolve_id][r];
            end
        end
`endif
        else if (accept) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (need[i]) map_d[rd_a[i]] = nt[i];
`ifdef RENAME_CHECKPOINT_EN
                // Snapshot includes this lane's write but none from younger lanes
                if (bus.dec_valid[i] && bus.is_branch[i]) begin
                    for (int unsigned r = 0; r < ARCH_REGS; r++) ckpt_d[slot][r] = map_d[r];
                    slot = slot + 1'b1;
                end
`endif
            end
        end
    end

`ifdef RENAME_CHECKPOINT_EN
    // Stack pointers, occupancy and done bits
    always_comb begin
        logic [CW-1:0] rel_id;
        logic [CW-1:0] rel_s;
        logic [CW-1:0] slot;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        rel_id  = bus.br_resolve_id - head_q;
        rel_s   = '0;
        slot    = tail_q;
        if (bus.flush_all) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = '0;
        end else begin
            if (bus.br_resolve_valid && !bus.br_mispredict) done_d[bus.br_resolve_id] = 1'b1;
            if (pop) begin
                done_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            if (misp) begin
                // Keep head..id-1, drop id and everything younger
                tail_d  = bus.br_resolve_id;
                count_d = {1'b0, rel_id} - CNTW'(pop);
                for (int unsigned s = 0; s < NUM_CKPT; s++) begin
                    rel_s = CW'(s) - head_q;
                    if (rel_s >= rel_id) done_d[s] = 1'b0;
                end
            end else if (accept) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (bus.dec_valid[i] && bus.is_branch[i]) begin
                        done_d[slot] = 1'b0;
                        slot = slot + 1'b1;
                    end
                end
                tail_d  = slot;
                count_d = count_q - CNTW'(pop) + CNTW'(br_n);
            end else begin
                count_d = count_q - CNTW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Snapshot storage needs no reset: a slot is only read after being allocated
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_CKPT; s++) begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) ckpt_q[s][r] <= ckpt_d[s][r];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) map_q[r] <= tag_t'(r);
        end else begin
            for (int unsigned r = 0; r < ARCH_REGS; r++) map_q[r] <= map_d[r];
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;

    localparam int LANES = 3;
    localparam int AW    = 5;
    localparam int PW    = 6;
    localparam int CW    = 2;
`ifdef RENAME_CHECKPOINT_EN
    localparam int EXP_FREE = 4;
`else
    localparam int EXP_FREE = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rename_map_table_if #(.LANES(3), .ARCH_REGS(32), .PHYS_REGS(64), .NUM_CKPT(4)) bus ();

    rename_map_table #(
        .LANES(3), .ARCH_REGS(32), .PHYS_REGS(64), .NUM_CKPT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [3*PW-1:0] v3(input int l0, input int l1, input int l2);
        return {PW'(l2), PW'(l1), PW'(l0)};
    endfunction

    task automatic idle();
        bus.dec_valid = '0; bus.rs1_arch = '0; bus.rs2_arch = '0; bus.rd_arch = '0;
        bus.rd_we = '0; bus.new_tag = '0; bus.new_tag_valid = '0; bus.is_branch = '0;
        bus.commit_valid = '0; bus.commit_arch = '0; bus.commit_tag = '0;
        bus.br_resolve_valid = 1'b0; bus.br_resolve_id = '0; bus.br_mispredict = 1'b0;
        bus.flush_all = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input int rs1, input int rs2, input int rd,
                            input bit we, input int tag, input bit br);
        bus.dec_valid[i]           = 1'b1;
        bus.rs1_arch[i*AW +: AW]   = AW'(rs1);
        bus.rs2_arch[i*AW +: AW]   = AW'(rs2);
        bus.rd_arch[i*AW +: AW]    = AW'(rd);
        bus.rd_we[i]               = we;
        bus.new_tag[i*PW +: PW]    = PW'(tag);
        bus.new_tag_valid[i]       = we;
        bus.is_branch[i]           = br;
    endtask

    task automatic set_commit(input int k, input int arch, input int tag);
        bus.commit_valid[k]          = 1'b1;
        bus.commit_arch[k*AW +: AW]  = AW'(arch);
        bus.commit_tag[k*PW +: PW]   = PW'(tag);
    endtask

    // Reads three map entries through lane rs1 lookups (no writes)
    task automatic probe(input int a0, input int a1, input int a2);
        idle();
        set_lane(0, a0, 0, 0, 0, 0, 0);
        set_lane(1, a1, 0, 0, 0, 0, 0);
        set_lane(2, a2, 0, 0, 0, 0, 0);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %b want 0", bus.stall); end
        checks++; if (bus.rs1_phys !== '0 || bus.rename_valid !== '0) begin errors++;
            $display("FAIL reset_idle_outputs: got %h/%b want 0/0", bus.rs1_phys, bus.rename_valid); end
        checks++; if (bus.ckpt_free !== 3'(EXP_FREE)) begin errors++;
            $display("FAIL reset_ckpt_free: got %0d want %0d", bus.ckpt_free, EXP_FREE); end
        probe(5, 7, 31);
        checks++; if (bus.rs1_phys !== v3(5, 7, 31)) begin errors++;
            $display("FAIL reset_identity: got %h want %h", bus.rs1_phys, v3(5, 7, 31)); end
        idle();
    endtask

    task automatic test_rename();
        idle();
        set_lane(0, 5, 0, 5, 1, 40, 0);
        set_lane(1, 0, 5, 5, 1, 41, 0);
        set_lane(2, 5, 0, 7, 1, 42, 0);
        #1;
        checks++; if (bus.rs1_phys !== v3(5, 0, 41)) begin errors++;
            $display("FAIL rename_rs1_bypass: got %h want %h", bus.rs1_phys, v3(5, 0, 41)); end
        checks++; if (bus.rs2_phys !== v3(0, 40, 0)) begin errors++;
            $display("FAIL rename_rs2_bypass: got %h want %h", bus.rs2_phys, v3(0, 40, 0)); end
        checks++; if (bus.old_rd_phys !== v3(5, 40, 7)) begin errors++;
            $display("FAIL rename_old_rd: got %h want %h", bus.old_rd_phys, v3(5, 40, 7)); end
        checks++; if (bus.rd_phys !== v3(40, 41, 42)) begin errors++;
            $display("FAIL rename_rd: got %h want %h", bus.rd_phys, v3(40, 41, 42)); end
        checks++; if (bus.stall !== 1'b0 || bus.tag_consume !== 3'b111 ||
                      bus.rename_valid !== 3'b111) begin errors++;
            $display("FAIL rename_accept: got stall=%b tc=%b rv=%b want 0/111/111",
                     bus.stall, bus.tag_consume, bus.rename_valid); end
        step();
        probe(5, 7, 0);
        checks++; if (bus.rs1_phys !== v3(41, 42, 0)) begin errors++;
            $display("FAIL rename_map_update: got %h want %h", bus.rs1_phys, v3(41, 42, 0)); end
        idle();
    endtask

    task automatic test_stall();
        idle();
        set_lane(0, 0, 0, 8, 1, 43, 0);
        set_lane(1, 0, 0, 9, 1, 44, 0);
        set_lane(2, 0, 0, 10, 1, 45, 0);
        bus.new_tag_valid = 3'b101;
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.tag_consume !== 3'b000 ||
                      bus.rename_valid !== 3'b000) begin errors++;
            $display("FAIL stall_no_tag: got stall=%b tc=%b rv=%b want 1/000/000",
                     bus.stall, bus.tag_consume, bus.rename_valid); end
        step();
        probe(8, 9, 10);
        checks++; if (bus.rs1_phys !== v3(8, 9, 10)) begin errors++;
            $display("FAIL stall_map_unchanged: got %h want %h", bus.rs1_phys, v3(8, 9, 10)); end
        // Writing x0 needs no tag, so a missing tag there does not stall
        idle();
        set_lane(0, 0, 0, 8, 1, 43, 0);
        set_lane(1, 0, 0, 0, 1, 44, 0);
        set_lane(2, 0, 0, 10, 1, 45, 0);
        bus.new_tag_valid = 3'b101;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.tag_consume !== 3'b101 ||
                      bus.rd_phys !== v3(43, 0, 45)) begin errors++;
            $display("FAIL x0_no_tag: got stall=%b tc=%b rd=%h want 0/101/%h",
                     bus.stall, bus.tag_consume, bus.rd_phys, v3(43, 0, 45)); end
        step();
        probe(8, 0, 10);
        checks++; if (bus.rs1_phys !== v3(43, 0, 45)) begin errors++;
            $display("FAIL x0_map: got %h want %h", bus.rs1_phys, v3(43, 0, 45)); end
        idle();
    endtask

    task automatic test_commit();
        // Map now: x5=41 x7=42 x8=43 x10=45
        idle();
        set_lane(0, 7, 0, 0, 0, 0, 0);
        set_commit(0, 5, 40);
        set_commit(1, 7, 42);
        #1;
        checks++; if (bus.rs1_phys !== v3(42, 0, 0)) begin errors++;
            $display("FAIL commit_not_yet_visible: got %h want %h", bus.rs1_phys, v3(42, 0, 0)); end
        step();
        probe(5, 7, 0);
        checks++; if (bus.rs1_phys !== v3(41, 7, 0)) begin errors++;
            $display("FAIL commit_clear: got %h want %h", bus.rs1_phys, v3(41, 7, 0)); end
        idle();
        set_lane(0, 0, 0, 8, 1, 46, 0);
        set_commit(0, 8, 43);
        set_commit(1, 10, 45);
        step();
        probe(8, 10, 0);
        checks++; if (bus.rs1_phys !== v3(46, 10, 0)) begin errors++;
            $display("FAIL commit_vs_rename: got %h want %h", bus.rs1_phys, v3(46, 10, 0)); end
        idle();
    endtask

    task automatic test_flush();
        idle();
        set_lane(0, 0, 0, 12, 1, 50, 0);
        bus.flush_all = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.rename_valid !== 3'b000) begin errors++;
            $display("FAIL flush_stall: got stall=%b rv=%b want 1/000", bus.stall, bus.rename_valid); end
        step();
        probe(5, 8, 12);
        checks++; if (bus.rs1_phys !== v3(5, 8, 12)) begin errors++;
            $display("FAIL flush_identity: got %h want %h", bus.rs1_phys, v3(5, 8, 12)); end
        idle();
    endtask

`ifndef RENAME_CHECKPOINT_EN
    task automatic test_no_ckpt();
        for (int g = 0; g < 2; g++) begin
            idle();
            set_lane(0, 0, 0, 0, 0, 0, 1);
            set_lane(1, 0, 0, 0, 0, 0, 1);
            set_lane(2, 0, 0, 0, 0, 0, 1);
            #1;
            checks++; if (bus.stall !== 1'b0 || bus.ckpt_id !== '0) begin errors++;
                $display("FAIL branch_ignored: got stall=%b id=%h want 0/0", bus.stall, bus.ckpt_id); end
            step();
        end
        idle();
        set_lane(0, 0, 0, 13, 1, 51, 1);
        bus.br_resolve_valid = 1'b1;
        bus.br_mispredict = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.tag_consume !== 3'b001 ||
                      bus.ckpt_free !== '0) begin errors++;
            $display("FAIL mispredict_ignored: got stall=%b tc=%b free=%0d want 0/001/0",
                     bus.stall, bus.tag_consume, bus.ckpt_free); end
        step();
        probe(13, 0, 0);
        checks++; if (bus.rs1_phys !== v3(51, 0, 0)) begin errors++;
            $display("FAIL no_ckpt_rename: got %h want %h", bus.rs1_phys, v3(51, 0, 0)); end
        idle();
    endtask
`else
    task automatic test_mispredict();
        reset_dut();
        set_lane(0, 0, 0, 3, 1, 33, 1);
        set_lane(1, 0, 0, 3, 1, 34, 0);
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.rename_valid !== 3'b011 ||
                      bus.ckpt_id !== 6'b00_00_00) begin errors++;
            $display("FAIL br_alloc: got stall=%b rv=%b id=%b want 0/011/000000",
                     bus.stall, bus.rename_valid, bus.ckpt_id); end
        step();
        probe(3, 0, 0);
        checks++; if (bus.rs1_phys !== v3(34, 0, 0) || bus.ckpt_free !== 3'd3) begin errors++;
            $display("FAIL br_after_alloc: got x3=%h free=%0d want %h/3",
                     bus.rs1_phys, bus.ckpt_free, v3(34, 0, 0)); end
        idle();
        set_lane(0, 0, 0, 4, 1, 50, 0);
        bus.br_resolve_valid = 1'b1;
        bus.br_mispredict = 1'b1;
        bus.br_resolve_id = 2'd0;
        #1;
        checks++; if (bus.stall !== 1'b1 || bus.tag_consume !== 3'b000) begin errors++;
            $display("FAIL misp_stall: got stall=%b tc=%b want 1/000", bus.stall, bus.tag_consume); end
        step();
        probe(3, 4, 0);
        checks++; if (bus.rs1_phys !== v3(33, 4, 0) || bus.ckpt_free !== 3'd4) begin errors++;
            $display("FAIL misp_restore: got map=%h free=%0d want %h/4",
                     bus.rs1_phys, bus.ckpt_free, v3(33, 4, 0)); end
        idle();
    endtask

    task automatic test_ckpt_full();
        bit acc;
        reset_dut();
        set_lane(0, 0, 0, 0, 0, 0, 1);
        set_lane(1, 0, 0, 0, 0, 0, 1);
        set_lane(2, 0, 0, 0, 0, 0, 1);
        #1;
        checks++; if (bus.ckpt_id !== 6'b10_01_00) begin errors++;
            $display("FAIL ckpt_consecutive: got %b want 100100", bus.ckpt_id); end
        step();
        idle();
        set_lane(0, 0, 0, 0, 0, 0, 1);
        #1;
        checks++; if (bus.ckpt_free !== 3'd1 || bus.ckpt_id[1:0] !== 2'd3) begin errors++;
            $display("FAIL ckpt_fourth: got free=%0d id=%0d want 1/3", bus.ckpt_free, bus.ckpt_id[1:0]); end
        step();
        idle();
        set_lane(0, 0, 0, 6, 1, 47, 1);
        #1;
        checks++; if (bus.ckpt_free !== 3'd0 || bus.stall !== 1'b1 ||
                      bus.tag_consume !== 3'b000) begin errors++;
            $display("FAIL ckpt_full_stall: got free=%0d stall=%b tc=%b want 0/1/000",
                     bus.ckpt_free, bus.stall, bus.tag_consume); end
        bus.is_branch = '0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++;
            $display("FAIL full_nonbranch_ok: got stall=%b want 0", bus.stall); end
        idle();
        bus.br_resolve_valid = 1'b1;
        bus.br_resolve_id = 2'd0;
        step();
        idle();
        set_lane(0, 0, 0, 6, 1, 47, 1);
        acc = 1'b0;
        for (int c = 0; c < 4 && !acc; c++) begin
            #1;
            if (bus.stall === 1'b0) acc = 1'b1;
            else step();
        end
        checks++; if (!acc || bus.ckpt_id[1:0] !== 2'd0 || bus.tag_consume !== 3'b001) begin errors++;
            $display("FAIL resolve_frees_slot: got acc=%b id=%0d tc=%b want 1/0/001",
                     acc, bus.ckpt_id[1:0], bus.tag_consume); end
        step();
        idle();
        #1;
        checks++; if (bus.ckpt_free !== 3'd0) begin errors++;
            $display("FAIL wrap_full: got free=%0d want 0", bus.ckpt_free); end
    endtask

    task automatic test_ckpt_commit();
        reset_dut();
        set_lane(0, 0, 0, 3, 1, 33, 0);
        step();
        idle();
        set_lane(0, 0, 0, 0, 0, 0, 1);
        set_lane(1, 0, 0, 3, 1, 34, 0);
        step();
        idle();
        set_commit(0, 3, 33);
        step();
        probe(3, 0, 0);
        checks++; if (bus.rs1_phys !== v3(34, 0, 0)) begin errors++;
            $display("FAIL commit_live_kept: got %h want %h", bus.rs1_phys, v3(34, 0, 0)); end
        idle();
        bus.br_resolve_valid = 1'b1;
        bus.br_mispredict = 1'b1;
        bus.br_resolve_id = 2'd0;
        step();
        probe(3, 0, 0);
        checks++; if (bus.rs1_phys !== v3(3, 0, 0)) begin errors++;
            $display("FAIL commit_in_ckpt: got %h want %h", bus.rs1_phys, v3(3, 0, 0)); end
        idle();
    endtask
`endif

    task automatic test_reset_mid();
        reset_dut();
        set_lane(0, 0, 0, 9, 1, 55, 1);
        set_lane(1, 0, 0, 0, 0, 0, 1);
        step();
        idle();
`ifdef RENAME_CHECKPOINT_EN
        #1;
        checks++; if (bus.ckpt_free !== 3'd2) begin errors++;
            $display("FAIL mid_two_live: got free=%0d want 2", bus.ckpt_free); end
        bus.br_resolve_valid = 1'b1;
        bus.br_mispredict = 1'b1;
        bus.br_resolve_id = 2'd1;
`else
        set_lane(0, 0, 0, 9, 1, 56, 0);
`endif
        reset = 1'b0;
        #1;
        checks++; if (bus.ckpt_free !== 3'(EXP_FREE)) begin errors++;
            $display("FAIL mid_reset_free: got %0d want %0d", bus.ckpt_free, EXP_FREE); end
        probe(9, 0, 0);
        checks++; if (bus.rs1_phys !== v3(9, 0, 0)) begin errors++;
            $display("FAIL mid_reset_identity: got %h want %h", bus.rs1_phys, v3(9, 0, 0)); end
        reset = 1'b1;
        idle();
        step();
        probe(9, 0, 0);
        checks++; if (bus.rs1_phys !== v3(9, 0, 0) || bus.ckpt_free !== 3'(EXP_FREE)) begin errors++;
            $display("FAIL post_reset: got %h free=%0d want %h/%0d",
                     bus.rs1_phys, bus.ckpt_free, v3(9, 0, 0), EXP_FREE); end
        idle();
    endtask

    initial begin
        idle();
        reset_dut();
        test_reset();
        test_rename();
        test_stall();
        test_commit();
        test_flush();
`ifdef RENAME_CHECKPOINT_EN
        test_mispredict();
        test_ckpt_full();
        test_ckpt_commit();
`else
        test_no_ckpt();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Parametrised N-wide register rename map for the superscalar issue stage. It maps architectural registers to physical tags, where tags 0..ARCH_REGS-1 name the architectural register file and higher tags name in-flight results. Unlike the fixed 3-wide map, it takes per-lane tags from an external free list and renames groups atomically. It also keeps an ordered checkpoint stack of map snapshots for single-cycle branch-mispredict recovery, and clears committed tags from both the live map and all checkpoints.

## Interface
- LANES, 3, rename lanes per cycle
- ARCH_REGS, 32, architectural registers
- PHYS_REGS, 64, physical tag space
- NUM_CKPT, 4, checkpoint slots (power of 2)
- AW, $clog2(ARCH_REGS), arch address width
- PW, $clog2(PHYS_REGS), tag width
- CW, $clog2(NUM_CKPT), checkpoint id width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, async active-low reset
- dec_valid  in  LANES  lane i carries an instruction
- rs1_arch / rs2_arch / rd_arch  in  LANES*AW  lane i at [i*AW +: AW]
- rd_we  in  LANES  lane i writes rd
- new_tag  in  LANES*PW  free-list tag offered to lane i
- new_tag_valid  in  LANES  new_tag lane i usable
- is_branch  in  LANES  lane i needs a checkpoint
- rs1_phys / rs2_phys / rd_phys / old_rd_phys  out  LANES*PW  renamed tags
- rename_valid  out  LANES  lane i renamed this cycle
- tag_consume  out  LANES  free list pops new_tag lane i
- ckpt_id  out  LANES*CW  checkpoint id for branch lane i
- stall  out  1  group rejected this cycle
- ckpt_free  out  CW+1  unused checkpoint slots
- commit_valid  in  LANES  ROB commit lane i
- commit_arch  in  LANES*AW  committed rd
- commit_tag  in  LANES*PW  committed tag
- br_resolve_valid  in  1  branch resolved
- br_resolve_id  in  CW  its checkpoint
- br_mispredict  in  1  resolved branch mispredicted
- flush_all  in  1  full pipeline flush

## Operation
- need_i = dec_valid[i] & rd_we[i] & rd_arch_i != 0.
- x0 always maps to tag 0 and is never written.
- Group accept requires both of the following; otherwise stall=1, all rename_valid/tag_consume=0, no state change:
  - new_tag_valid[i] for every need_i;
  - count of dec_valid[i]&is_branch[i] <= ckpt_free.
- On accept, rename_valid[i]=dec_valid[i]. tag_consume[i]=need_i. rd_phys_i=new_tag_i if need_i, else 0. old_rd_phys_i=mapping of rd_arch_i as seen after lanes <i (0 if !need_i).
- Source bypass: a lane-j source takes the youngest lane i<j with need_i and rd_arch_i equal to that source; otherwise it reads the registered map. Sources equal to x0 give 0.
- Map update: lanes apply in order, so the highest lane wins on equal rd_arch.
- Checkpoints: an ordered circular stack with head (oldest) and tail.
  - A branch lane i allocates the slot at tail, increments tail, and sets ckpt_id_i to that slot.
  - The snapshot equals the map after lanes 0..i of the group, excluding younger lanes.
  - Several branch lanes in one group take consecutive slots.
- Correct resolve (br_resolve_valid & !br_mispredict): mark slot done. Each cycle, if the head slot is done, free it and advance head (one slot per cycle).
- Mispredict: copy snapshot br_resolve_id into the map. Free that slot and all younger ones (tail = id), clear their done bits, and force stall=1 with no rename that cycle.
- Commit lane k: if map[commit_arch_k]==commit_tag_k, set it to {0,commit_arch_k}. Apply the same rule to every live checkpoint.
- flush_all: map to identity, all checkpoints freed, stall=1.
- Same-cycle priority: flush_all > mispredict > (commit, then rename). Commit clears are applied on top of a restored snapshot. A rename of the same arch register wins over a commit clear.

## Timing
- Rename outputs are combinational from inputs and the registered map. All state updates at posedge clk.
- Commit effects are visible to sources on the next cycle.
- Restore is single-cycle: a group presented in the cycle after the mispredict sees the restored map.
- Reset (async, any time including mid-group or mid-recovery):
  - map = identity;
  - head=tail=0, no done bits;
  - ckpt_free=NUM_CKPT.
- With dec_valid=0, all renamed outputs are 0 and stall=0.
- Wrap-around: head/tail are modulo NUM_CKPT. Full vs empty is distinguished by an occupancy counter, so ckpt_free=0 means full.

## Configuration
- RENAME_CHECKPOINT_EN defined: checkpoint stack, ckpt_id, br_resolve_* and mispredict recovery exist as above.
- Not defined:
  - no snapshot storage;
  - is_branch ignored for acceptance;
  - ckpt_id=0 and ckpt_free=0;
  - br_resolve_* ignored;
  - recovery only via flush_all.

## Test plan
- Reset, then group lanes rd=x5,x5,x7 with tags 40,41,42 and lane2 rs1=x5: rs1_phys_2=41, old_rd_phys_1=40, next-cycle map x5=41, x7=42.
- Lane1 needs a tag but new_tag_valid=3'b101: stall=1, tag_consume=0, map unchanged.
- Lane0 branch after x3->33, lane1 x3->34, then mispredict id 0: map x3=33 next cycle, ckpt_free back to NUM_CKPT.
- Fill all 4 checkpoints, then branch group: stall=1. Resolve oldest correct: slot freed next cycle and the branch is accepted after.
- Commit x3 tag 33 while map x3=34 and checkpoint holds x3=33: map stays 34, checkpoint becomes 3. Mispredict then restores x3=3.
- Assert reset mid-recovery with 2 live checkpoints: identity map, ckpt_free=4 immediately.
